// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between bus masters and the round-robin arbiter.
interface bus_arbiter_rr_if #(
  parameter int unsigned NUM_MASTERS = 2
);
  localparam int unsigned MW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] breq;
  logic                   tend;
  logic                   ssplit;
  logic                   sresume;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [MW-1:0]          msel;
  logic                   bus_busy;
  logic [NUM_MASTERS-1:0] msplit;
  logic                   split_busy;
  logic                   split_grant;
  logic                   timeout;

  // Arbiter view: samples requests and slave pulses, drives grants.
  modport slave (
    input  breq, tend, ssplit, sresume,
    output bgrant, msel, bus_busy, msplit, split_busy, split_grant, timeout
  );

  // Requester/slave-side view.
  modport master (
    output breq, tend, ssplit, sresume,
    input  bgrant, msel, bus_busy, msplit, split_busy, split_grant, timeout
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with a single split-transaction slot and a
// bus-hold timeout. Grants are registered: one cycle from breq to bgrant,
// and one idle turnaround cycle after every release.
module bus_arbiter_rr #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned HOLD_MAX    = 16
) (
  input logic              clk,
  input logic              rstn,
  bus_arbiter_rr_if.slave  bus
);
  localparam int unsigned MW = $clog2(NUM_MASTERS);
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
  logic [MW-1:0]          msel_q, msel_d;
  logic [MW-1:0]          last_q, last_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [NUM_MASTERS-1:0] msplit_q, msplit_d;
  logic                   split_busy_q, split_busy_d;
  logic                   resume_pend_q, resume_pend_d;
  logic                   split_grant_q, split_grant_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0] elig;
  logic                   rr_found;
  logic [MW-1:0]          rr_idx;
  logic [MW-1:0]          cand;
  logic [MW-1:0]          split_idx;

  // A parked master is masked out of normal arbitration.
  assign elig = bus.breq & ~msplit_q;

  // Round-robin scan starting just after the last granted master.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
      cand = MW'((int'(last_q) + i) % int'(NUM_MASTERS));
      if (!rr_found && elig[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Encode the one-hot split flag into the parked master's index.
  always_comb begin
    split_idx = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (msplit_q[i]) split_idx = MW'(i);
    end
  end

  // Next-state: arbitration in idle, release conditions while busy.
  always_comb begin
    state_d       = state_q;
    bgrant_d      = bgrant_q;
    msel_d        = msel_q;
    last_d        = last_q;
    hold_d        = hold_q;
    msplit_d      = msplit_q;
    split_busy_d  = split_busy_q;
    resume_pend_d = resume_pend_q;
    split_grant_d = 1'b0;
    timeout_d     = 1'b0;

    // Judged on registered state, so a SPLIT accepted this edge cannot be resumed yet.
    if (bus.sresume && split_busy_q && !resume_pend_q) resume_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (resume_pend_q && bus.breq[split_idx]) begin
          state_d       = StBusy;
          bgrant_d      = NUM_MASTERS'(1) << split_idx;
          msel_d        = split_idx;
          last_d        = split_idx;
          hold_d        = HW'(1);
          msplit_d      = '0;
          split_busy_d  = 1'b0;
          resume_pend_d = 1'b0;
          split_grant_d = 1'b1;
        end else if (rr_found) begin
          state_d  = StBusy;
          bgrant_d = NUM_MASTERS'(1) << rr_idx;
          msel_d   = rr_idx;
          last_d   = rr_idx;
          hold_d   = HW'(1);
        end
      end
      StBusy: begin
        if (bus.tend || !bus.breq[msel_q]) begin
          state_d  = StIdle;
          bgrant_d = '0;
        end else if (bus.ssplit && !split_busy_q) begin
          state_d      = StIdle;
          bgrant_d     = '0;
          msplit_d     = msplit_q | (NUM_MASTERS'(1) << msel_q);
          split_busy_d = 1'b1;
        end else if (hold_q == HW'(HOLD_MAX)) begin
          state_d   = StIdle;
          bgrant_d  = '0;
          timeout_d = 1'b1;
        end else if (hold_q != '1) begin
          // A SPLIT while the slot is occupied lands here and is ignored.
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= StIdle;
      bgrant_q      <= '0;
      msel_q        <= '0;
      last_q        <= MW'(NUM_MASTERS - 1);
      hold_q        <= '0;
      msplit_q      <= '0;
      split_busy_q  <= 1'b0;
      resume_pend_q <= 1'b0;
      split_grant_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bgrant_q      <= bgrant_d;
      msel_q        <= msel_d;
      last_q        <= last_d;
      hold_q        <= hold_d;
      msplit_q      <= msplit_d;
      split_busy_q  <= split_busy_d;
      resume_pend_q <= resume_pend_d;
      split_grant_q <= split_grant_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.bgrant      = bgrant_q;
  assign bus.msel        = msel_q;
  assign bus.bus_busy    = (state_q == StBusy);
  assign bus.msplit      = msplit_q;
  assign bus.split_busy  = split_busy_q;
  assign bus.split_grant = split_grant_q;
  assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios then random traffic, all
// checked against an integer-level model of the arbitration rules.
module tb_bus_arbiter_rr;
  localparam int N  = 2;
  localparam int HM = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bus_arbiter_rr_if #(.NUM_MASTERS(N)) bus ();

  bus_arbiter_rr #(
    .NUM_MASTERS(N),
    .HOLD_MAX   (HM)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus, for how long, and who is parked.
  int m_busy, m_owner, m_last, m_hold, m_sown, m_rp, m_sg, m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic [N-1:0] b, input logic t, input logic s,
                       input logic res);
    int  g;
    int  c;
    bit  acc;
    m_sg = 0;
    m_to = 0;
    if (!r) begin
      m_busy = 0; m_owner = 0; m_last = N - 1; m_hold = 0; m_sown = -1; m_rp = 0;
      return;
    end
    acc = res && (m_sown >= 0) && (m_rp == 0);
    if (m_busy == 0) begin
      g = -1;
      if (m_rp != 0 && b[m_sown]) begin
        g = m_sown; m_sown = -1; m_rp = 0; m_sg = 1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (g < 0 && b[c] && c != m_sown) g = c;
        end
      end
      if (g >= 0) begin
        m_busy = 1; m_owner = g; m_last = g; m_hold = 1;
      end
    end else begin
      if (t || !b[m_owner]) m_busy = 0;
      else if (s && m_sown < 0) begin
        m_sown = m_owner; m_busy = 0;
      end else if (m_hold == HM) begin
        m_to = 1; m_busy = 0;
      end else m_hold++;
    end
    if (acc) m_rp = 1;
  endtask

  task automatic step(input logic r, input logic [N-1:0] b, input logic t, input logic s,
                      input logic res);
    rstn        = r;
    bus.breq    = b;
    bus.tend    = t;
    bus.ssplit  = s;
    bus.sresume = res;
    @(posedge clk);
    model(r, b, t, s, res);
    #1;
    check("bgrant", 32'(bus.bgrant), (m_busy != 0) ? (32'd1 << m_owner) : 32'd0);
    check("msel", 32'(bus.msel), 32'(m_owner));
    check("bus_busy", 32'(bus.bus_busy), 32'(m_busy));
    check("msplit", 32'(bus.msplit), (m_sown >= 0) ? (32'd1 << m_sown) : 32'd0);
    check("split_busy", 32'(bus.split_busy), (m_sown >= 0) ? 32'd1 : 32'd0);
    check("split_grant", 32'(bus.split_grant), 32'(m_sg));
    check("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  logic [N-1:0] rb;
  logic         rt, rs, rr, rst_n;

  initial begin
    model(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(0, 2'b00, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0);

    // Single request, grant then release with turnaround
    step(1, 2'b01, 0, 0, 0);
    step(1, 2'b01, 1, 0, 0);
    step(1, 2'b00, 0, 0, 0);

    // Both requesting: alternate with tend on every third busy cycle
    step(0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b11, 0, 0, 0);
      step(1, 2'b11, 0, 0, 0);
      step(1, 2'b11, 0, 0, 0);
      step(1, 2'b11, 1, 0, 0);
    end

    // Split of M0, M1 served, second split ignored, then resume priority
    step(0, 2'b00, 0, 0, 0);
    step(1, 2'b01, 0, 0, 0);
    step(1, 2'b11, 0, 1, 0);
    step(1, 2'b11, 0, 0, 0);
    step(1, 2'b11, 0, 1, 0);
    step(1, 2'b11, 0, 0, 1);
    step(1, 2'b11, 1, 0, 0);
    step(1, 2'b11, 0, 0, 0);
    step(1, 2'b11, 0, 0, 0);
    step(1, 2'b11, 1, 0, 0);

    // Hold timeout on M1, then M0 takes over
    step(0, 2'b00, 0, 0, 0);
    step(1, 2'b10, 0, 0, 0);
    for (int i = 0; i < HM + 2; i++) step(1, 2'b11, 0, 0, 0);

    // Reset while M0 busy and M1 parked, then M1 requests alone
    step(0, 2'b00, 0, 0, 0);
    step(1, 2'b10, 0, 0, 0);
    step(1, 2'b11, 0, 1, 0);
    step(1, 2'b11, 0, 0, 0);
    step(1, 2'b11, 0, 0, 0);
    step(0, 2'b11, 0, 0, 0);
    step(1, 2'b10, 0, 0, 0);
    step(1, 2'b10, 1, 0, 0);

    // Random traffic
    rb = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rb = N'($urandom());
      rt    = ($urandom_range(9) == 0);
      rs    = ($urandom_range(11) == 0);
      rr    = ($urandom_range(11) == 0);
      rst_n = ($urandom_range(499) != 0);
      step(rst_n, rb, rt, rs, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin system-bus arbiter for NUM_MASTERS masters, with split-transaction tracking and a bus-hold timeout.
- Sits between the master request lines and the bus mux: drives one-hot grants and the master-select index.
- Parks a master when a split-capable slave responds SPLIT, and gives it top priority when that slave signals resume.
- One split outstanding at a time.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
HOLD_MAX, 16, max consecutive BUSY cycles before grant is revoked (>=2)
MW, $clog2(NUM_MASTERS), width of msel (derived localparam)

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
breq  input  NUM_MASTERS  bus request, one bit per master, level
tend  input  1  one-cycle pulse: granted master's transaction complete
ssplit  input  1  one-cycle pulse: addressed slave issued SPLIT to current owner
sresume  input  1  one-cycle pulse: split slave ready to complete parked transaction
bgrant  output  NUM_MASTERS  one-hot grant, registered, all-zero when idle
msel  output  MW  index of granted master (holds last value when idle)
bus_busy  output  1  high while in BUSY
msplit  output  NUM_MASTERS  one-hot flag of parked split master
split_busy  output  1  split slot occupied; slave must not issue another SPLIT
split_grant  output  1  one-cycle pulse in the first BUSY cycle of a resumed master
timeout  output  1  one-cycle pulse when grant revoked by HOLD_MAX

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; bgrant, msplit, split_grant, timeout = 0; msel=0; split_busy=0; resume_pend=0; hold counter=0; rr pointer last=NUM_MASTERS-1, so master 0 has first priority. Reset mid-transaction or with a split outstanding clears everything identically.
- Eligible set E = breq & ~msplit.
- States: IDLE, BUSY.
- IDLE, arbitration:
  - If resume_pend=1 and breq[owner]=1: grant owner, clear msplit and resume_pend, pulse split_grant.
  - Else if E≠0: grant the first set bit of E scanning from last+1, wrapping.
  - Grant registers on the same edge that samples the request. Latency is 1 cycle from breq to bgrant.
  - Go to BUSY; last = granted index; hold counter=1.
  - If resume_pend=1 but breq[owner]=0: the owner keeps its priority, and other eligible masters are served normally.
- BUSY: bgrant and msel held. Priority order at each edge:
  1. tend=1, or breq[owner]=0 (abandon): release, go to IDLE. bgrant=0 in the next cycle, giving one turnaround cycle. If ssplit is in the same cycle, tend wins.
  2. ssplit=1 and split_busy=0: set msplit[owner], split_busy=1, release, go to IDLE.
  3. ssplit=1 and split_busy=1: ignored (protocol violation); transaction continues.
  4. Hold counter = HOLD_MAX: pulse timeout, release, go to IDLE.
  5. Otherwise: increment hold counter (saturating width $clog2(HOLD_MAX+1)).
- sresume:
  - Sets resume_pend when split_busy=1 and resume_pend=0; ignored otherwise.
  - Evaluated against registered state: an sresume in the same cycle as an accepting ssplit is ignored.
  - When the resumed owner is granted, split_busy clears.
- The split owner's breq is masked while msplit is set, even if asserted.
- A timeout or abandon by a non-split master has no effect on split state.
- bus_busy = (state==BUSY).
- At most one bgrant bit is ever set.
- A master is never granted two consecutive times while another eligible master requests, except via resume priority.

Test Plan:
1. Reset, breq=01 → next cycle bgrant=01, msel=0, bus_busy=1. Pulse tend → next cycle bgrant=00, bus_busy=0.
2. From reset, breq=11 held, tend every 3rd BUSY cycle → grants alternate 01,10,01,10, each separated by one idle cycle.
3. M0 granted, ssplit pulse → next cycle bgrant=00, msplit=01, split_busy=1. M0 breq held high, M1 breq=1 → M1 granted, M0 never granted. A second ssplit during M1 → ignored, bgrant stays 10.
4. Continue 3: sresume while M1 BUSY, M1 keeps breq=1 → after M1 tend and one idle cycle, bgrant=01, split_grant=1 for one cycle, msplit=00, split_busy=0.
5. M1 granted, no tend for 16 cycles → timeout=1 for one cycle, bgrant=00 next cycle. M0 (requesting) granted on the following arbitration.
6. M0 BUSY with M1 parked (msplit=10), rstn=0 for one cycle → bgrant=00, msplit=00, split_busy=0, msel=0. After release, breq=10 → M1 granted.
